// File: rtl/rtaudio_pkg.sv
// Shared rtaudio definitions: sample format limits and echo FSM state encodings.
package rtaudio_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MAX = 16'h7FFF;
  localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MIN = 16'h8000;

  localparam int unsigned STATE_WIDTH = 3;
  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_READ  = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_MIX   = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_WRITE = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_CLEAR = 3'd4;

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous delay-line RAM with registered read; maps onto block RAM.
module echo_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/audio_echo_effect.sv
// Feedback echo stage: mixes an attenuated delayed copy into each codec sample.
// Define AUDIO_ECHO_CLEAR_EN to zero the delay line after every reset.
module audio_echo_effect import rtaudio_pkg::*; #(
  parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FB_SHIFT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_end,
  input  logic [DATA_WIDTH-1:0] audio_input,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  output logic [DATA_WIDTH-1:0] audio_output,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

`ifdef AUDIO_ECHO_CLEAR_EN
  localparam logic [STATE_WIDTH-1:0] RESET_STATE = ST_CLEAR;
  localparam logic                   RESET_BUSY  = 1'b1;
`else
  localparam logic [STATE_WIDTH-1:0] RESET_STATE = ST_IDLE;
  localparam logic                   RESET_BUSY  = 1'b0;
`endif

  logic [STATE_WIDTH-1:0] state, state_next;
  logic [DATA_WIDTH-1:0]  x_q, sum_q, rdata, fb, sat, result, ram_wdata;
  logic [DATA_WIDTH:0]    wide;
  logic [ADDR_WIDTH-1:0]  len_q, len_m1, wr_ptr;
  logic                   en_q, ram_we;

  echo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (wr_ptr),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

  // Saturating mix of live sample and attenuated delayed sample.
  always_comb begin
    fb   = DATA_WIDTH'($signed(rdata) >>> FB_SHIFT);
    wide = {x_q[DATA_WIDTH-1], x_q} + {fb[DATA_WIDTH-1], fb};
    sat  = wide[DATA_WIDTH-1:0];
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) sat = wide[DATA_WIDTH] ? NEG_MIN : POS_MAX;
    result = en_q ? sum_q : x_q;
    // A zero length behaves as a one-sample delay.
    len_m1 = (len_q == '0) ? '0 : len_q - ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      busy  <= RESET_BUSY;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  // Next state and RAM write strobe; a write coinciding with reset is dropped.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    case (state)
      ST_IDLE:  if (sample_end) state_next = ST_READ;
      ST_READ:  state_next = ST_MIX;
      ST_MIX:   state_next = ST_WRITE;
      ST_WRITE: begin
        state_next = ST_IDLE;
        ram_we     = ~reset;
        ram_wdata  = result;
      end
`ifdef AUDIO_ECHO_CLEAR_EN
      ST_CLEAR: begin
        ram_we = ~reset;
        if (wr_ptr == '1) state_next = ST_IDLE;
      end
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_output <= '0;
      wr_ptr       <= '0;
      x_q          <= '0;
      sum_q        <= '0;
      len_q        <= '0;
      en_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (sample_end) begin
          x_q   <= audio_input;
          len_q <= delay_len;
          en_q  <= enable;
        end
        ST_MIX:   sum_q <= sat;
        ST_WRITE: begin
          audio_output <= result;
          wr_ptr       <= (wr_ptr >= len_m1) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        end
        ST_CLEAR: wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_echo_effect.sv
// Self-checking bench for audio_echo_effect against a sample-level echo model.
`timescale 1ns/1ps
module tb_audio_echo_effect;
  import rtaudio_pkg::*;

  localparam int DEPTH = 4096;
  localparam int FB    = 1;
  localparam int SMAX  = int'(SAMPLE_MAX);
  localparam int SMIN  = -int'(SAMPLE_MAX) - 1;

  logic        clk = 1'b0;
  logic        reset, sample_end, enable;
  logic [15:0] audio_input;
  logic [11:0] delay_len;
  logic [15:0] audio_output;
  logic        busy;

  always #5 clk = ~clk;

  audio_echo_effect #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .FB_SHIFT(FB)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_end   (sample_end),
    .audio_input  (audio_input),
    .enable       (enable),
    .delay_len    (delay_len),
    .audio_output (audio_output),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Behavioural model: a circular delay line of signed integers.
  int mem [DEPTH];
  int m_ptr = 0, m_len = 1, m_phase = 0, m_out = 0, m_pend = 0, m_clr = 0;
  bit m_busy = 1'b0;

  function automatic int to_s(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  initial foreach (mem[i]) mem[i] = 0;

  always @(posedge clk) begin : model
    int x;
    if (reset) begin
      m_phase = 0; m_out = 0; m_ptr = 0;
`ifdef AUDIO_ECHO_CLEAR_EN
      m_clr = DEPTH; m_busy = 1'b1;
`else
      m_clr = 0; m_busy = 1'b0;
`endif
    end else if (m_clr > 0) begin
      mem[DEPTH - m_clr] = 0;
      m_clr--;
      m_busy = (m_clr != 0);
    end else if (m_phase == 0) begin
      if (sample_end) begin
        x      = to_s(audio_input);
        m_pend = enable ? sat(x + (mem[m_ptr] >>> FB)) : x;
        m_len  = (delay_len == 0) ? 1 : int'(delay_len);
        m_phase = 1;
        m_busy  = 1'b1;
      end
    end else if (m_phase < 3) begin
      m_phase++;
    end else begin
      mem[m_ptr] = m_pend;
      m_out  = m_pend;
      m_ptr  = (m_ptr + 1 >= m_len) ? 0 : m_ptr + 1;
      m_phase = 0;
      m_busy  = 1'b0;
    end
  end

  // Cycle-by-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (audio_output !== 16'(m_out)) begin
        errors++;
        $display("FAIL out t=%0t got=%h exp=%h", $time, audio_output, 16'(m_out));
      end
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] exp);
    checks++;
    if (audio_output !== exp) begin
      errors++;
      $display("FAIL %s dut got=%h exp=%h", nm, audio_output, exp);
    end
    checks++;
    if (16'(m_out) !== exp) begin
      errors++;
      $display("FAIL %s model got=%h exp=%h", nm, 16'(m_out), exp);
    end
  endtask

  task automatic send(input logic [15:0] x, input logic en, input logic [11:0] len);
    @(negedge clk);
    audio_input = x; enable = en; delay_len = len; sample_end = 1'b1;
    @(negedge clk);
    sample_end  = 1'b0;
    audio_input = 16'($urandom);
  endtask

  task automatic send_wait(input logic [15:0] x, input logic en, input logic [11:0] len);
    send(x, en, len);
    repeat (3) @(negedge clk);
  endtask

  task automatic prime();
    for (int i = 0; i < 16; i++) send_wait(16'h0000, 1'b0, 12'd16);
  endtask

  task automatic wait_clear();
`ifdef AUDIO_ECHO_CLEAR_EN
    repeat (DEPTH + 4) @(negedge clk);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [15:0] byp [20];
    logic [15:0] x, e;
    int prev;
    reset = 1'b1; sample_end = 1'b0; enable = 1'b0;
    audio_input = '0; delay_len = 12'd4;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    lit("reset_out", 16'h0000);
    reset = 1'b0;
    wait_clear();

    // Impulse response, delay 4, halving each repeat.
    prime();
    for (int i = 0; i < 12; i++) begin
      send_wait((i == 0) ? 16'h4000 : 16'h0000, 1'b1, 12'd4);
      lit("impulse", (i == 0) ? 16'h4000 : (i == 4) ? 16'h2000 : (i == 8) ? 16'h1000 : 16'h0000);
    end

    // Positive and negative saturation with delay 2.
    prime();
    for (int i = 0; i < 6; i++) begin
      send_wait(16'h7000, 1'b1, 12'd2);
      lit("sat_pos", (i < 2) ? 16'h7000 : 16'h7FFF);
    end
    prime();
    for (int i = 0; i < 6; i++) begin
      send_wait(16'h9000, 1'b1, 12'd2);
      lit("sat_neg", (i < 2) ? 16'h9000 : 16'h8000);
    end

    // Bypass, then the bypassed samples echo back five samples later.
    for (int i = 0; i < 20; i++) begin
      byp[i] = 16'($urandom);
      send_wait(byp[i], 1'b0, 12'd5);
      lit("bypass", byp[i]);
    end
    for (int j = 0; j < 5; j++) begin
      x = 16'($urandom);
      send_wait(x, 1'b1, 12'd5);
      e = 16'(sat(to_s(x) + (to_s(byp[15 + j]) >>> 1)));
      lit("echo_after_bypass", e);
    end

    // Delay shrink 8 -> 3 with pointer at 6, then zero length acting as one.
    prime();
    for (int i = 0; i < 6; i++) send_wait(16'($urandom), 1'b1, 12'd8);
    for (int i = 0; i < 4; i++) send_wait(16'($urandom), 1'b1, 12'd3);
    send_wait(16'($urandom), 1'b1, 12'd0);
    prev = m_out;
    for (int i = 0; i < 4; i++) begin
      x = 16'($urandom);
      send_wait(x, 1'b1, 12'd0);
      e = 16'(sat(to_s(x) + (prev >>> 1)));
      lit("len_zero", e);
      prev = to_s(e);
    end

    // Back-to-back pulse: second one ignored.
    @(negedge clk);
    audio_input = 16'h1234; enable = 1'b1; delay_len = 12'd16; sample_end = 1'b1;
    @(negedge clk);
    audio_input = 16'h5678;
    @(negedge clk);
    sample_end = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) send_wait(16'($urandom), 1'b1, 12'd16);

    // Reset while the sample is in MIX.
    send(16'h2222, 1'b1, 12'd16);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lit("reset_in_mix", 16'h0000);
    reset = 1'b0;
    wait_clear();

    // Randomized traffic, including pulses that land while busy.
    delay_len = 12'd7;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) delay_len = 12'($urandom_range(0, 16));
      send(16'($urandom), ($urandom_range(0, 3) != 0), delay_len);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
